// File: rtl/ikbd_acia_if.sv
// CPU-side register bus of the keyboard ACIA: access strobe, direction, register
// select, write/read data and the active-low interrupt request.
interface ikbd_acia_if;
    logic       cpu_sel;
    logic       cpu_rw;
    logic       cpu_rs;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       irq_n;

    modport master (
        output cpu_sel, cpu_rw, cpu_rs, cpu_di,
        input  cpu_do, irq_n
    );

    modport slave (
        input  cpu_sel, cpu_rw, cpu_rs, cpu_di,
        output cpu_do, irq_n
    );
endinterface

// File: rtl/ikbd_acia.sv
// 6850-style ACIA linking the host CPU to the keyboard MCU's SCI: 8N1 framing,
// fixed bit period of CLK_DIV clocks, single-byte receive and transmit buffers.
module ikbd_acia #(
    parameter int CLK_DIV = 256
) (
    input  logic         mcu_clx2,
    input  logic         mcu_rst_n,
    ikbd_acia_if.slave   bus,
    input  logic         rxd,
    output logic         txd
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLK_DIV - 1);
    // Start detection already costs one clock after the synchronizer output
    // falls, so the mid-start sample lands CLK_DIV/2 clocks after that fall.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLK_DIV / 2 - 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    logic [7:0]       cr_reg;
    logic [7:0]       rdr_reg;
    logic [7:0]       tdr_reg;
    logic             rdrf_reg, ovrn_reg, fe_reg, tdre_reg, irq_n_reg;
    logic [1:0]       rx_sync_reg;
    logic             rx_prev_reg;
    rx_state_t        rx_state_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [2:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;
    tx_state_t        tx_state_reg;
    logic [CNT_W-1:0] tx_cnt_reg;
    logic [3:0]       tx_bit_reg;
    logic [9:0]       tx_shift_reg;

    logic wr_cr, wr_tdr, rd_rdr, mres, rie, tie, rx_bit, tx_load;
    logic unused_cr_bits;

    assign wr_cr   = bus.cpu_sel & ~bus.cpu_rw & ~bus.cpu_rs;
    assign wr_tdr  = bus.cpu_sel & ~bus.cpu_rw &  bus.cpu_rs;
    assign rd_rdr  = bus.cpu_sel &  bus.cpu_rw &  bus.cpu_rs;
    assign mres    = (cr_reg[1:0] == 2'b11);
    assign rie     = cr_reg[7];
    assign tie     = (cr_reg[6:5] == 2'b01);
    assign rx_bit  = rx_sync_reg[1];
    assign unused_cr_bits = ^cr_reg[4:2];

    // A pending byte is picked up from idle, or at the end of the stop bit so
    // consecutive frames run back-to-back.
    assign tx_load = ~tdre_reg &
                     ((tx_state_reg == TX_IDLE) ||
                      (tx_cnt_reg == BIT_LAST && tx_bit_reg == 4'd9));

    assign bus.cpu_do = bus.cpu_rs ? rdr_reg
                                   : {~irq_n_reg, 1'b0, ovrn_reg, fe_reg, 2'b00, tdre_reg, rdrf_reg};
    assign bus.irq_n  = irq_n_reg;
    assign txd        = tx_shift_reg[0];

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            cr_reg    <= 8'h03;
            irq_n_reg <= 1'b1;
        end else begin
            if (wr_cr)
                cr_reg <= bus.cpu_di;
            irq_n_reg <= ~((rie & (rdrf_reg | ovrn_reg)) | (tie & tdre_reg));
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rdr_reg      <= 8'h00;
            rdrf_reg     <= 1'b0;
            ovrn_reg     <= 1'b0;
            fe_reg       <= 1'b0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], rxd};
            rx_prev_reg <= rx_bit;
            if (mres) begin
                rx_state_reg <= RX_IDLE;
                rx_cnt_reg   <= '0;
                rx_bit_reg   <= '0;
                rdrf_reg     <= 1'b0;
                ovrn_reg     <= 1'b0;
                fe_reg       <= 1'b0;
            end else begin
                if (rd_rdr) begin
                    rdrf_reg <= 1'b0;
                    ovrn_reg <= 1'b0;
                end
                case (rx_state_reg)
                    RX_IDLE: begin
                        rx_cnt_reg <= '0;
                        if (rx_prev_reg && !rx_bit)
                            rx_state_reg <= RX_START;
                    end
                    RX_START: begin
                        if (rx_cnt_reg == START_LAST) begin
                            rx_cnt_reg   <= '0;
                            rx_bit_reg   <= '0;
                            rx_state_reg <= rx_bit ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt_reg == BIT_LAST) begin
                            rx_cnt_reg   <= '0;
                            rx_shift_reg <= {rx_bit, rx_shift_reg[7:1]};
                            rx_bit_reg   <= rx_bit_reg + 1'b1;
                            if (rx_bit_reg == 3'd7)
                                rx_state_reg <= RX_STOP;
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt_reg == BIT_LAST) begin
                            rx_cnt_reg   <= '0;
                            rx_state_reg <= RX_IDLE;
                            // A read on this very edge frees the buffer: the new byte wins.
                            if (!rdrf_reg || rd_rdr) begin
                                rdr_reg  <= rx_shift_reg;
                                rdrf_reg <= 1'b1;
                                fe_reg   <= ~rx_bit;
                                ovrn_reg <= 1'b0;
                            end else begin
                                ovrn_reg <= 1'b1;
                            end
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                    default: rx_state_reg <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '1;
            tdr_reg      <= 8'h00;
            tdre_reg     <= 1'b1;
        end else begin
            if (wr_tdr)
                tdr_reg <= bus.cpu_di;
            if (mres) begin
                tx_state_reg <= TX_IDLE;
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
                tx_shift_reg <= '1;
                tdre_reg     <= 1'b1;
            end else begin
                // A write coinciding with a load queues the new byte behind the old one.
                if (wr_tdr)
                    tdre_reg <= 1'b0;
                else if (tx_load)
                    tdre_reg <= 1'b1;
                case (tx_state_reg)
                    TX_IDLE: begin
                        tx_cnt_reg <= '0;
                        tx_bit_reg <= '0;
                        if (tx_load) begin
                            tx_shift_reg <= {1'b1, tdr_reg, 1'b0};
                            tx_state_reg <= TX_SHIFT;
                        end
                    end
                    TX_SHIFT: begin
                        if (tx_cnt_reg == BIT_LAST) begin
                            tx_cnt_reg <= '0;
                            if (tx_bit_reg == 4'd9) begin
                                tx_bit_reg <= '0;
                                if (tx_load) begin
                                    tx_shift_reg <= {1'b1, tdr_reg, 1'b0};
                                end else begin
                                    tx_shift_reg <= '1;
                                    tx_state_reg <= TX_IDLE;
                                end
                            end else begin
                                tx_bit_reg   <= tx_bit_reg + 1'b1;
                                tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                            end
                        end else begin
                            tx_cnt_reg <= tx_cnt_reg + 1'b1;
                        end
                    end
                    default: tx_state_reg <= TX_IDLE;
                endcase
            end
        end
    end
endmodule
